// File: rtl/icache_ctrl_sequencer.sv
// icache_ctrl_sequencer
//   Sequences ENABLE / DISABLE / FLUSH / INVAL commands from the cluster
//   peripheral front-end onto the control handshakes of NB_CACHE_BANKS
//   private instruction-cache banks.
//
//   Ports
//     clk_i, rst_ni            clock, async active-low reset
//     cmd_valid_i/cmd_ready_o  command handshake (ready only in IDLE)
//     cmd_op_i                 00 ENABLE, 01 DISABLE, 10 FLUSH, 11 INVAL
//     cmd_mask_i               target banks
//     busy_o, done_o, err_o    status; err_o qualifies the done_o pulse
//     enabled_o                tracked per-bank enable state
//     ctrl_req_*_o/flush_req_o per-bank level requests, held until acked
//     ctrl_ack_*_i/flush_ack_i per-bank acknowledges
//     ctrl_pending_trans_i     bank still has refills outstanding
//
//   Every output is decoded from state and registers; acks and pending
//   status only steer next-state logic.

// Per-bank acknowledge tracker: remembers that this bank has acked the
// current phase. Cleared outside request phases and on every phase exit.
module icache_seq_bank (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic sel_i,
    input  logic ack_i,
    output logic acked_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              acked_o <= 1'b0;
        else if (clr_i)           acked_o <= 1'b0;
        else if (sel_i && ack_i)  acked_o <= 1'b1;
    end
endmodule

module icache_ctrl_sequencer #(
    parameter int NB_CACHE_BANKS = 4,
    parameter int ACK_TIMEOUT    = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [NB_CACHE_BANKS-1:0] cmd_mask_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [NB_CACHE_BANKS-1:0] enabled_o,
    output logic [NB_CACHE_BANKS-1:0] ctrl_req_enable_o,
    output logic [NB_CACHE_BANKS-1:0] ctrl_req_disable_o,
    output logic [NB_CACHE_BANKS-1:0] flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] ctrl_ack_enable_i,
    input  logic [NB_CACHE_BANKS-1:0] ctrl_ack_disable_i,
    input  logic [NB_CACHE_BANKS-1:0] flush_ack_i,
    input  logic [NB_CACHE_BANKS-1:0] ctrl_pending_trans_i
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] OP_ENABLE  = 2'b00;
    localparam logic [1:0] OP_DISABLE = 2'b01;
    localparam logic [1:0] OP_FLUSH   = 2'b10;
    localparam logic [1:0] OP_INVAL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_DISABLE, S_DRAIN, S_FLUSH, S_ENABLE, S_DONE
    } state_e;

    state_e                    state_q, first_phase, next_phase;
    logic [1:0]                op_q;
    logic [NB_CACHE_BANKS-1:0] mask_q, acked_q, enabled_q, phase_ack;
    logic [CW-1:0]             cnt_q;
    logic                      err_q;
    logic                      req_phase, in_phase, phase_done, timeout, advance;

    always_comb begin
        req_phase = 1'b0;
        phase_ack = '0;
        case (state_q)
            S_DISABLE: begin req_phase = 1'b1; phase_ack = ctrl_ack_disable_i; end
            S_FLUSH:   begin req_phase = 1'b1; phase_ack = flush_ack_i;        end
            S_ENABLE:  begin req_phase = 1'b1; phase_ack = ctrl_ack_enable_i;  end
            default: ;
        endcase
        in_phase = req_phase || (state_q == S_DRAIN);
        // Request phases finish on registered acks; DRAIN on live pending.
        phase_done = (state_q == S_DRAIN) ? ((ctrl_pending_trans_i & mask_q) == '0)
                                          : (acked_q == mask_q);
        // cnt_q counts cycles already spent in the phase, so the phase is
        // given exactly ACK_TIMEOUT cycles.
        timeout = (cnt_q == CW'(ACK_TIMEOUT - 1));
        advance = in_phase && (phase_done || timeout);
    end

    always_comb begin
        case (cmd_op_i)
            OP_ENABLE:  first_phase = S_ENABLE;
            OP_DISABLE: first_phase = S_DISABLE;
            OP_FLUSH:   first_phase = S_DRAIN;
            default:    first_phase = S_DISABLE;
        endcase
        // An empty mask spends its single phase cycle, then goes to DONE.
        next_phase = S_DONE;
        if (mask_q != '0) begin
            case (state_q)
                S_DISABLE: if (op_q == OP_INVAL) next_phase = S_DRAIN;
                S_DRAIN:   next_phase = S_FLUSH;
                S_FLUSH:   if (op_q == OP_INVAL) next_phase = S_ENABLE;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NB_CACHE_BANKS; i++) begin : g_bank
        icache_seq_bank u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (!req_phase || advance),
            .sel_i   (mask_q[i]),
            .ack_i   (phase_ack[i]),
            .acked_o (acked_q[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ENABLE;
            mask_q    <= '0;
            enabled_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_op_i;
                        mask_q  <= cmd_mask_i;
                        state_q <= first_phase;
                        cnt_q   <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                end
                default: begin
                    if (phase_done) begin
                        state_q <= next_phase;
                        cnt_q   <= '0;
                        if (state_q == S_ENABLE)  enabled_q <= enabled_q | mask_q;
                        if (state_q == S_DISABLE) enabled_q <= enabled_q & ~mask_q;
                    end else if (timeout) begin
                        // Abort: partial acks of this phase are not applied.
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o        = (state_q == S_IDLE);
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = (state_q == S_DONE);
    assign err_o              = (state_q == S_DONE) && err_q;
    assign enabled_o          = enabled_q;
    assign ctrl_req_enable_o  = (state_q == S_ENABLE)  ? (mask_q & ~acked_q) : '0;
    assign ctrl_req_disable_o = (state_q == S_DISABLE) ? (mask_q & ~acked_q) : '0;
    assign flush_req_o        = (state_q == S_FLUSH)   ? (mask_q & ~acked_q) : '0;

endmodule

// File: tb/tb_icache_ctrl_sequencer.sv
// Testbench for icache_ctrl_sequencer. Each command is described by per-bank
// ack delays (cycles of request before the ack, 0 = never) and pending
// durations; a phase-level timing model derives the expected request
// vectors, enable state and done/err timing for every cycle.
module tb_icache_ctrl_sequencer;
    localparam int NB    = 4;
    localparam int TO    = 8;
    localparam int NEVER = 0;
    localparam int K_DIS = 1, K_DR = 2, K_FL = 3, K_EN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [NB-1:0] cmd_mask = '0;
    logic          busy, done, err;
    logic [NB-1:0] enabled, req_en, req_dis, req_fl;
    logic [NB-1:0] ack_en = '0, ack_dis = '0, ack_fl = '0, pending = '0;

    int checks = 0;
    int errors = 0;
    int d_en[NB], d_dis[NB], d_fl[NB], pend[NB];
    logic [NB-1:0] en_model = '0;
    int obs;

    always #5 clk = ~clk;

    icache_ctrl_sequencer #(.NB_CACHE_BANKS(NB), .ACK_TIMEOUT(TO)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .cmd_valid_i          (cmd_valid),
        .cmd_ready_o          (cmd_ready),
        .cmd_op_i             (cmd_op),
        .cmd_mask_i           (cmd_mask),
        .busy_o               (busy),
        .done_o               (done),
        .err_o                (err),
        .enabled_o            (enabled),
        .ctrl_req_enable_o    (req_en),
        .ctrl_req_disable_o   (req_dis),
        .flush_req_o          (req_fl),
        .ctrl_ack_enable_i    (ack_en),
        .ctrl_ack_disable_i   (ack_dis),
        .flush_ack_i          (ack_fl),
        .ctrl_pending_trans_i (pending)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int dval(input int kd, input int b);
        case (kd)
            K_DIS:   return d_dis[b];
            K_FL:    return d_fl[b];
            K_EN:    return d_en[b];
            default: return pend[b];
        endcase
    endfunction

    // Cycles a phase needs to complete: last ack/pending-clear plus one.
    function automatic int phase_need(input int kd, input logic [NB-1:0] m);
        int need = 1;
        int d;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) begin
                d = dval(kd, b);
                if (kd == K_DR)          d = d + 1;
                else if (d == NEVER)     d = 1000;
                else                     d = d + 1;
                if (d > need) need = d;
            end
        end
        return need;
    endfunction

    task automatic set_all(input int de, input int dd, input int df, input int p);
        for (int b = 0; b < NB; b++) begin
            d_en[b] = de; d_dis[b] = dd; d_fl[b] = df; pend[b] = p;
        end
    endtask

    // Called in an IDLE cycle (#1 after posedge); returns in the next IDLE cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [NB-1:0] mask,
                           input bit noise, output int obs_done);
        int kinds[4];
        int st[4], du[4];
        bit ok[4];
        logic [NB-1:0] enu[4];
        int nph, t, used, need, ph, kd, d, rel;
        bit err_m, ab;
        logic [NB-1:0] en, en_cur, exp_req;

        case (op)
            2'b00:   begin kinds[0] = K_EN;  nph = 1; end
            2'b01:   begin kinds[0] = K_DIS; nph = 1; end
            2'b10:   begin kinds[0] = K_DR;  kinds[1] = K_FL; nph = 2; end
            default: begin kinds[0] = K_DIS; kinds[1] = K_DR; kinds[2] = K_FL;
                           kinds[3] = K_EN;  nph = 4; end
        endcase
        t = 1; used = 0; err_m = 1'b0; en = en_model;
        for (int i = 0; i < nph; i++) begin
            ok[i] = 1'b0;
            need = (mask == '0) ? 1 : phase_need(kinds[i], mask);
            st[i] = t;
            used = i + 1;
            if (need > TO) begin
                du[i] = TO; t += TO; err_m = 1'b1;
                break;
            end
            du[i] = need; t += need; ok[i] = 1'b1;
            if (kinds[i] == K_EN)  en = en | mask;
            if (kinds[i] == K_DIS) en = en & ~mask;
            enu[i] = en;
            if (mask == '0) break;
        end

        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask;
        ack_en  = noise ? NB'($urandom) : '0;
        ack_dis = noise ? NB'($urandom) : '0;
        ack_fl  = noise ? NB'($urandom) : '0;
        pending = noise ? NB'($urandom) : '0;
        chk("accept_ready", 32'(cmd_ready), 1);
        chk("accept_busy", 32'(busy), 0);

        en_cur = en_model;
        obs_done = -1;
        for (int k = 1; k <= t; k++) begin
            @(posedge clk); #1;
            ph = -1;
            for (int i = 0; i < used; i++) begin
                if (k >= st[i] && k < st[i] + du[i]) ph = i;
                if (ok[i] && k == st[i] + du[i]) en_cur = enu[i];
            end
            kd = (ph < 0) ? 0 : kinds[ph];
            rel = (ph < 0) ? 0 : k - st[ph];
            cmd_valid = noise ? 1'($urandom) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_mask  = NB'($urandom);
            ack_en  = noise ? NB'($urandom) : '0;
            ack_dis = noise ? NB'($urandom) : '0;
            ack_fl  = noise ? NB'($urandom) : '0;
            pending = noise ? NB'($urandom) : '0;
            exp_req = '0;
            for (int b = 0; b < NB; b++) begin
                if (mask[b] && (kd == K_DIS || kd == K_FL || kd == K_EN)) begin
                    d = dval(kd, b);
                    exp_req[b] = (d == NEVER) || (rel < d);
                    ab = (d != NEVER) && ((rel == d - 1) ||
                         (noise && rel > d - 1 && $urandom_range(0, 1) == 1));
                    case (kd)
                        K_DIS:   ack_dis[b] = ab;
                        K_FL:    ack_fl[b]  = ab;
                        default: ack_en[b]  = ab;
                    endcase
                end else if (mask[b] && kd == K_DR) begin
                    pending[b] = (rel < pend[b]);
                end
            end
            chk("req_enable",  32'(req_en),  32'((kd == K_EN)  ? exp_req : '0));
            chk("req_disable", 32'(req_dis), 32'((kd == K_DIS) ? exp_req : '0));
            chk("req_flush",   32'(req_fl),  32'((kd == K_FL)  ? exp_req : '0));
            chk("busy",        32'(busy),      1);
            chk("ready",       32'(cmd_ready), 0);
            chk("done",        32'(done),      32'(k == t));
            chk("err",         32'(err),       32'((k == t) && err_m));
            chk("enabled",     32'(enabled),   32'(en_cur));
            if (done && obs_done < 0) obs_done = k;
        end

        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ack_en = '0; ack_dis = '0; ack_fl = '0; pending = '0;
        chk("idle_ready",   32'(cmd_ready), 1);
        chk("idle_done",    32'(done),      0);
        chk("idle_enabled", 32'(enabled),   32'(en));
        en_model = en;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   32'(cmd_ready), 1);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_done",    32'(done),      0);
        chk("rst_err",     32'(err),       0);
        chk("rst_enabled", 32'(enabled),   0);
        chk("rst_reqs",    32'(req_en | req_dis | req_fl), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ENABLE, both acks in first request cycle
        set_all(1, 1, 1, 0);
        run_cmd(2'b00, 4'b0101, 1'b0, obs);
        chk("enable_latency", 32'(obs), 3);
        chk("enable_state", 32'(enabled), 32'(4'b0101));

        // FLUSH with bank1 draining 5 cycles and acking 3 cycles after bank0
        set_all(1, 1, 1, 0);
        pend[1] = 5; d_fl[1] = 4;
        run_cmd(2'b10, 4'b0011, 1'b0, obs);
        chk("flush_latency", 32'(obs), 12);

        // INVAL on all-enabled banks
        set_all(1, 1, 1, 0);
        run_cmd(2'b00, 4'b1111, 1'b0, obs);
        run_cmd(2'b11, 4'b1111, 1'b0, obs);
        chk("inval_latency", 32'(obs), 8);
        chk("inval_state", 32'(enabled), 32'(4'b1111));

        // DISABLE with bank2 silent: timeout abort
        set_all(1, 1, 1, 0);
        d_dis[2] = NEVER;
        run_cmd(2'b01, 4'b1111, 1'b0, obs);
        chk("timeout_latency", 32'(obs), 9);
        chk("timeout_state", 32'(enabled), 32'(4'b1111));

        // Empty mask, every op, back to back
        for (int op = 0; op < 4; op++) begin
            run_cmd(2'(op), 4'b0000, 1'b0, obs);
            chk("mask0_latency", 32'(obs), 2);
        end

        // Randomized commands with noise on unrelated acks/pending/cmd_valid
        for (int n = 0; n < 40; n++) begin
            for (int b = 0; b < NB; b++) begin
                d_en[b]  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8);
                d_dis[b] = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8);
                d_fl[b]  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8);
                pend[b]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8)
                                                       : $urandom_range(0, 2);
            end
            run_cmd(2'($urandom), ($urandom_range(0, 5) == 0) ? '0 : NB'($urandom),
                    1'b1, obs);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("gap_ready", 32'(cmd_ready), 1);
            end
        end

        // Make sure some bank is enabled, then reset mid-FLUSH
        set_all(1, 1, 1, 0);
        run_cmd(2'b00, 4'b1010, 1'b0, obs);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 4'b1010;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_flush_req", 32'(req_fl), 32'(4'b1010));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flush_req", 32'(req_fl),    0);
        chk("mid_rst_ready",     32'(cmd_ready), 1);
        chk("mid_rst_enabled",   32'(enabled),   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en_model = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done",  32'(done),      0);
            chk("post_rst_ready", 32'(cmd_ready), 1);
        end
        set_all(2, 2, 2, 1);
        run_cmd(2'b00, 4'b0001, 1'b0, obs);
        chk("post_rst_latency", 32'(obs), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
